data_mem_ctrl: RTL and testbench

Word-addressed data memory with a wait-state controller, sitting directly downstream of the execution stage register and serving the memory stage. It takes the load/store command and ALU-computed byte address from the EXE/MEM boundary and returns load data. It drives a ready signal that freezes the whole pipeline while an access is in flight. It models a slow SRAM so that hazard and freeze logic can be exercised before real external memory is integrated.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/data_mem_array.sv | 30 +++
 rtl/data_mem_ctrl.sv | 99 +++++++++
 tb/tb_data_mem_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state data memory: FSM encoding, word width,
// default base address and the index-width helper.
package mem_pkg;

    localparam int WORD_W        = 32;
    localparam int BASE_ADDR_DEF = 1024;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x WORD_W storage, cleared by reset; synchronous write, combinational read.
// Latency: write lands on the clock edge, read is same-cycle; no backpressure.
module data_mem_array #(
    parameter int DEPTH  = 64,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdat,
    output logic [WORD_W-1:0] rdat
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdat;
        end
    end

    assign rdat = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory that models a slow SRAM behind the EXE/MEM register.
// Latency: LATENCY+1 frozen cycles per access; ready low stalls the whole pipeline.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = BASE_ADDR_DEF,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_En,
    input  logic        MEM_W_En,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] ST_val,
    output logic [31:0] MEM_result,
    output logic        ready
);

    localparam int         IDX_W  = clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [3:0]        cnt;
    logic              req;
    logic              commit;
    logic [31:0]       offset;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] rdat;
    logic              unused_bits;

    assign req    = MEM_R_En | MEM_W_En;
    assign ready  = ~req | (state == DONE);

    // Byte offset from the window base; the upper bits fall away so addresses wrap.
    assign offset      = ALU_Result - 32'(BASE_ADDR);
    assign idx         = offset[IDX_W+1:2];
    assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0]};

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_nxt = DONE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // A vanished request (flush) abandons the access without touching memory.
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt == LAT_M1) begin
                    state_nxt = DONE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            MEM_result <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
            if (commit && MEM_R_En && !MEM_W_En) begin
                MEM_result <= rdat;
            end
        end
    end

    data_mem_array #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (commit & MEM_W_En),
        .addr (idx),
        .wdat (ST_val),
        .rdat (rdat)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (LATENCY 2, 0, 3) checked every cycle
// against a freeze-length memory model, plus directed literal expectations.
module tb_data_mem_ctrl;

    localparam int LATS [3] = '{2, 0, 3};

    logic        clk;
    logic        rst;
    logic        r_en [3];
    logic        w_en [3];
    logic [31:0] addr [3];
    logic [31:0] st   [3];
    logic [31:0] res  [3];
    logic        rdy  [3];

    int tests;
    int fails;

    // Model: per instance, number of frozen cycles seen so far and whether this is the release cycle.
    int          busy   [3];
    bit          done_m [3];
    logic [31:0] mres   [3];
    logic [31:0] mmem   [3][64];

    data_mem_ctrl #(.DEPTH(64), .BASE_ADDR(1024), .LATENCY(2)) u0 (
        .clk(clk), .rst(rst), .MEM_R_En(r_en[0]), .MEM_W_En(w_en[0]),
        .ALU_Result(addr[0]), .ST_val(st[0]), .MEM_result(res[0]), .ready(rdy[0]));
    data_mem_ctrl #(.DEPTH(64), .BASE_ADDR(1024), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst), .MEM_R_En(r_en[1]), .MEM_W_En(w_en[1]),
        .ALU_Result(addr[1]), .ST_val(st[1]), .MEM_result(res[1]), .ready(rdy[1]));
    data_mem_ctrl #(.DEPTH(64), .BASE_ADDR(1024), .LATENCY(3)) u2 (
        .clk(clk), .rst(rst), .MEM_R_En(r_en[2]), .MEM_W_En(w_en[2]),
        .ALU_Result(addr[2]), .ST_val(st[2]), .MEM_result(res[2]), .ready(rdy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int midx(input logic [31:0] a);
        return int'(((a - 32'd1024) >> 2) % 32'd64);
    endfunction

    // Per-cycle comparison against the model, then advance the model past the coming edge.
    initial begin : cmp
        bit req;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                req = r_en[i] | w_en[i];
                if (rst) begin
                    check($sformatf("cyc_rst_ready%0d", i), {31'b0, rdy[i]}, 32'd1);
                    check($sformatf("cyc_rst_result%0d", i), res[i], 32'd0);
                    busy[i]   = 0;
                    done_m[i] = 1'b0;
                    mres[i]   = 32'd0;
                    for (int k = 0; k < 64; k++) mmem[i][k] = 32'd0;
                end else begin
                    check($sformatf("cyc_ready%0d", i), {31'b0, rdy[i]}, {31'b0, (!req || done_m[i])});
                    check($sformatf("cyc_result%0d", i), res[i], mres[i]);
                    if (done_m[i]) begin
                        done_m[i] = 1'b0;
                        busy[i]   = 0;
                    end else if (req) begin
                        if (busy[i] == LATS[i]) begin
                            if (w_en[i]) mmem[i][midx(addr[i])] = st[i];
                            else         mres[i] = mmem[i][midx(addr[i])];
                            done_m[i] = 1'b1;
                        end else begin
                            busy[i]++;
                        end
                    end else begin
                        busy[i] = 0;
                    end
                end
            end
        end
    end

    task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int exp_low, input bit chk,
                          input logic [31:0] exp_res, input string name);
        int low;
        bit seen;
        @(posedge clk); #1;
        r_en[i] = r; w_en[i] = w; addr[i] = a; st[i] = d;
        low  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy[i]) begin
                seen = 1'b1;
                break;
            end
            low++;
        end
        check({name, "_released"}, {31'b0, seen}, 32'd1);
        check({name, "_low_cycles"}, low, exp_low);
        if (chk) check({name, "_data"}, res[i], exp_res);
        @(posedge clk); #1;
        r_en[i] = 1'b0; w_en[i] = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_en[i] = 1'b0; w_en[i] = 1'b0; addr[i] = 32'd0; st[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ready%0d", i), {31'b0, rdy[i]}, 32'd1);
            check($sformatf("reset_result%0d", i), res[i], 32'd0);
        end

        // LATENCY=2: store then load
        access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 3, 1'b0, 32'd0, "st_1028");
        access(0, 1'b1, 1'b0, 32'd1028, 32'd0, 3, 1'b1, 32'hDEADBEEF, "ld_1028");
        // Wrap and ignored low address bits
        access(0, 1'b0, 1'b1, 32'd1280, 32'h11, 3, 1'b0, 32'd0, "st_wrap");
        access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 3, 1'b1, 32'h11, "ld_1024");
        access(0, 1'b1, 1'b0, 32'd1027, 32'd0, 3, 1'b1, 32'h11, "ld_1027");
        // Both enables: store wins, result held
        access(0, 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 3, 1'b1, 32'h11, "rw_1032");
        access(0, 1'b1, 1'b0, 32'd1032, 32'd0, 3, 1'b1, 32'hA5A5A5A5, "ld_1032");

        // LATENCY=0
        access(1, 1'b1, 1'b0, 32'd1024, 32'd0, 1, 1'b1, 32'd0, "l0_ld_init");
        access(1, 1'b0, 1'b1, 32'd1024, 32'h5, 1, 1'b0, 32'd0, "l0_st");
        access(1, 1'b1, 1'b0, 32'd1024, 32'd0, 1, 1'b1, 32'h5, "l0_ld");

        // LATENCY=3: store abandoned in its second wait cycle
        @(posedge clk); #1;
        w_en[2] = 1'b1; addr[2] = 32'd1036; st[2] = 32'h77;
        @(negedge clk);
        check("abort_first_cycle_ready", {31'b0, rdy[2]}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        w_en[2] = 1'b0;
        @(negedge clk);
        check("abort_drop_ready", {31'b0, rdy[2]}, 32'd1);
        @(posedge clk); #1;
        access(2, 1'b1, 1'b0, 32'd1036, 32'd0, 4, 1'b1, 32'd0, "abort_ld_1036");

        // Reset in the middle of a LATENCY=2 load
        @(posedge clk); #1;
        r_en[0] = 1'b1; addr[0] = 32'd1028;
        @(posedge clk); #1;
        rst = 1'b1; r_en[0] = 1'b0;
        #1;
        check("midrst_ready", {31'b0, rdy[0]}, 32'd1);
        check("midrst_result", res[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        access(0, 1'b1, 1'b0, 32'd1028, 32'd0, 3, 1'b1, 32'd0, "postrst_ld_1028");
        access(0, 1'b1, 1'b0, 32'd1032, 32'd0, 3, 1'b1, 32'd0, "postrst_ld_1032");

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
